// File: rtl/banner_scroller.sv
// Scrolling message banner for an N_DIGITS multiplexed 7-segment display.
// Generates its own scan and scroll ticks; anodos/segmentos drive the board pins directly.
module banner_scroller #(
  parameter  int CLK_XTAL    = 50_000_000,
  parameter  int CLK_DISPLAY = 240,
  parameter  int CLK_BANNER  = 1,
  parameter  int N_DIGITS    = 4,
  parameter  int MSG_LEN     = 16,
  localparam int AW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [4:0]          wr_data,
  input  logic                dir,
  input  logic                pause,
  input  logic                blink_en,
  output logic [N_DIGITS-1:0] anodos,
  output logic [7:0]          segmentos,
  output logic                shift,
  output logic                wrap
);

  localparam int DIV_D = CLK_XTAL / CLK_DISPLAY;
  localparam int DIV_B = CLK_XTAL / CLK_BANNER;
  localparam int DW    = $clog2(DIV_D);
  localparam int BW    = $clog2(DIV_B);
  localparam int L     = N_DIGITS + MSG_LEN;
  localparam int PW    = $clog2(L);
  localparam int SW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DW-1:0] cnt_d;
  logic [BW-1:0] cnt_b;
  logic          tick_d;
  logic          tick_b;
  logic [PW-1:0] pos;
  logic [SW-1:0] sel;
  logic          blink_phase;
  logic [4:0]    msg [MSG_LEN];
  logic [4:0]    ch;
  logic [7:0]    glyph;
  logic          wr_ok;
  int            stream_idx;

  assign tick_d = (cnt_d == DW'(DIV_D - 1));
  assign tick_b = (cnt_b == BW'(DIV_B - 1));
  assign wr_ok  = wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

  // NOTE: all state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_d <= '0;
      cnt_b <= '0;
    end else begin
      cnt_d <= tick_d ? '0 : cnt_d + 1'b1;
      cnt_b <= tick_b ? '0 : cnt_b + 1'b1;
    end
  end

  // Scroll position, blink phase and the step/wrap pulses all move on tick_b.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos         <= '0;
      blink_phase <= 1'b0;
      shift       <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      shift <= 1'b0;
      wrap  <= 1'b0;
      if (tick_b) begin
        blink_phase <= ~blink_phase;
        if (!pause) begin
          shift <= 1'b1;
          if (!dir) begin
            if (pos == PW'(L - 1)) begin
              pos  <= '0;
              wrap <= 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              pos  <= PW'(L - 1);
              wrap <= 1'b1;
            end else begin
              pos <= pos - 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= '0;
    end else if (tick_d) begin
      sel <= (sel == SW'(N_DIGITS - 1)) ? '0 : sel + 1'b1;
    end
  end

  // NOTE: the message buffer is flops, not RAM, so it can and must reset to blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= 5'h10;
    end else if (wr_ok) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Leading N_DIGITS stream slots are blank padding ahead of the message.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ch         = 5'h10;
    stream_idx = int'(pos) + (N_DIGITS - 1) - int'(sel);
    if (stream_idx >= L) stream_idx = stream_idx - L;
    if (stream_idx >= N_DIGITS) ch = msg[AW'(stream_idx - N_DIGITS)];
  end

  always_comb begin
    glyph = 8'hFF;
    if (!ch[4]) begin
      case (ch[3:0])
        4'h0: glyph = 8'hC0;
        4'h1: glyph = 8'hF9;
        4'h2: glyph = 8'hA4;
        4'h3: glyph = 8'hB0;
        4'h4: glyph = 8'h99;
        4'h5: glyph = 8'h92;
        4'h6: glyph = 8'h82;
        4'h7: glyph = 8'hF8;
        4'h8: glyph = 8'h80;
        4'h9: glyph = 8'h90;
        4'hA: glyph = 8'h88;
        4'hB: glyph = 8'h83;
        4'hC: glyph = 8'hC6;
        4'hD: glyph = 8'hA1;
        4'hE: glyph = 8'h86;
        default: glyph = 8'h8E;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodos    <= '1;
      segmentos <= 8'hFF;
    end else begin
      anodos    <= (blink_en && blink_phase) ? '1 : ~(N_DIGITS'(1) << sel);
      segmentos <= glyph;
    end
  end

endmodule
